// File: rtl/uart_rx_param.sv
`timescale 1ns/1ps
// Parametrised UART receiver with synchroniser, 3-sample majority vote, framing/break detection; even parity when UART_RX_PARITY_EN is defined.
// Latency: valid rises one cycle after the vote of the final stop bit, half a bit before the stop bit ends.
// Backpressure: none; valid/frame_err/parity_err are single-cycle strobes that must be taken when offered.
module uart_rx_param #(
    parameter int CLK_FREQUENCY  = 66_000_000,
    parameter int UART_FREQUENCY = 921_600,
    parameter int DATA_BITS      = 8,
    parameter int STOP_BITS      = 1,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic                 valid,
    output logic [DATA_BITS-1:0] data,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int TICKS = CLK_FREQUENCY / UART_FREQUENCY;
    localparam int HALF  = TICKS / 2;
    localparam int CW    = $clog2(TICKS) + 1;
    localparam int IW    = $clog2(DATA_BITS);

    if (TICKS < 8) begin : g_chk_ticks
        $error("uart_rx_param: CLK_FREQUENCY/UART_FREQUENCY must be at least 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
        $error("uart_rx_param: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
        $error("uart_rx_param: STOP_BITS must be 1 or 2");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_chk_sync
        $error("uart_rx_param: SYNC_STAGES must be 2..4");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [CW-1:0]          tick;
    logic [IW-1:0]          bit_idx;
    logic                   stop_idx;
    logic                   samp_a, samp_b;
    logic [DATA_BITS-1:0]   shreg;
    logic                   stop_bad, stop_one;
    logic                   vote, at_vote, tick_end, last_stop;
    logic                   done, fail, brk;

    assign rx_s      = sync_q[SYNC_STAGES-1];
    assign vote      = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
    assign at_vote   = (tick == CW'(HALF + 1));
    assign tick_end  = (tick == CW'(TICKS - 1));
    assign last_stop = (STOP_BITS == 1) || stop_idx;
    assign done      = (state == S_STOP) && at_vote && last_stop;
    assign fail      = done && (stop_bad || !vote);
    // Break: all data bits and every stop bit low
    assign brk       = fail && !stop_one && !vote && (shreg == '0);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!rx_s) state_nxt = S_START;
            S_START: begin
                if (at_vote && vote)  state_nxt = S_IDLE;
                else if (tick_end)    state_nxt = S_DATA;
            end
            S_DATA: begin
                if (tick_end && bit_idx == IW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                    state_nxt = S_PARITY;
`else
                    state_nxt = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: if (tick_end) state_nxt = S_STOP;
`endif
            S_STOP:  if (done) state_nxt = brk ? S_BREAK : S_IDLE;
            S_BREAK: if (rx_s) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // The IDLE cycle that first sees rx_s low counts as tick 0 of the start bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick     <= '0;
            samp_a   <= 1'b1;
            samp_b   <= 1'b1;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            stop_bad <= 1'b0;
            stop_one <= 1'b0;
        end else begin
            if (state_nxt == S_IDLE)  tick <= '0;
            else if (state == S_IDLE) tick <= CW'(1);
            else if (tick_end)        tick <= '0;
            else                      tick <= tick + CW'(1);

            if (tick == CW'(HALF - 1)) samp_a <= rx_s;
            if (tick == CW'(HALF))     samp_b <= rx_s;

            case (state)
                S_IDLE: begin
                    bit_idx  <= '0;
                    stop_idx <= 1'b0;
                    stop_bad <= 1'b0;
                    stop_one <= 1'b0;
                end
                S_DATA: begin
                    if (at_vote)  shreg   <= {vote, shreg[DATA_BITS-1:1]};
                    if (tick_end) bit_idx <= bit_idx + IW'(1);
                end
                S_STOP: begin
                    if (at_vote) begin
                        if (vote) stop_one <= 1'b1;
                        else      stop_bad <= 1'b1;
                    end
                    if (tick_end) stop_idx <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            data      <= '0;
        end else begin
            valid     <= done && !fail;
            frame_err <= fail;
            if (done && !fail) data <= shreg;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (state == S_IDLE)                 par_bad <= 1'b0;
            else if (state == S_PARITY && at_vote) par_bad <= (vote != ^shreg);
            parity_err <= done && !fail && par_bad;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
`timescale 1ns/1ps
// Directed bench for uart_rx_param: 10 ns clock, 710 ns nominal bit (71 clocks).
module tb_uart_rx_param;

`ifdef UART_RX_PARITY_EN
    localparam int DB   = 7;
    localparam int SB   = 2;
    localparam int NPAR = 1;
`else
    localparam int DB   = 8;
    localparam int SB   = 1;
    localparam int NPAR = 0;
`endif
    localparam int BIT_NS = 710;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx  = 1'b1;
    logic          valid, frame_err, parity_err, busy;
    logic [DB-1:0] data;

    int          cyc = 0;
    int          vcnt = 0, fcnt = 0, pcnt = 0, ovl = 0, vcyc = 0;
    logic [23:0] hist = '0;
    int          n_cmp = 0, n_bad = 0;
    int          s;

    uart_rx_param #(.DATA_BITS(DB), .STOP_BITS(SB)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .valid      (valid),
        .data       (data),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            vcnt++;
            vcyc = cyc;
            hist = {hist[15:0], 8'(data)};
            if (parity_err) pcnt++;
        end
        if (frame_err) fcnt++;
        if (parity_err && !valid) ovl++;
        if (valid && frame_err) ovl++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_neg(input int target);
        @(negedge clk);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic send_frame(input logic [8:0] w, input logic par_flip, input logic stop_v, input int bit_ns);
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < DB; i++) begin
            rx = w[i];
            #(bit_ns);
        end
        for (int i = 0; i < NPAR; i++) begin
            rx = (^w[DB-1:0]) ^ par_flip;
            #(bit_ns);
        end
        for (int i = 0; i < SB; i++) begin
            rx = stop_v;
            #(bit_ns);
        end
        rx = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_strobes_busy", 32'({valid, frame_err, parity_err, busy}), 32'h0);
        chk("reset_data", 32'(data), 32'h0);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;

`ifdef UART_RX_PARITY_EN
        // 0x41 has two ones, so the even-parity bit is 0
        send_frame(9'h041, 1'b0, 1'b1, BIT_NS);
        repeat (50) @(posedge clk);
        #1;
        chk("par_ok_vcnt", 32'(vcnt), 32'd1);
        chk("par_ok_data", 32'(data), 32'h41);
        chk("par_ok_perr", 32'(pcnt), 32'd0);
        send_frame(9'h041, 1'b1, 1'b1, BIT_NS);
        repeat (50) @(posedge clk);
        #1;
        chk("par_bad_vcnt", 32'(vcnt), 32'd2);
        chk("par_bad_data", 32'(data), 32'h41);
        chk("par_bad_perr", 32'(pcnt), 32'd1);
        chk("par_fcnt", 32'(fcnt), 32'd0);
`else
        // Start bit: rx_s falls 2 clocks after the line; stop vote at tick 36 of bit 9 -> valid 2+9*71+36+1 = 678 clocks after the edge
        s = cyc;
        send_frame(9'h0A5, 1'b0, 1'b1, BIT_NS);
        chk("a5_vcnt", 32'(vcnt), 32'd1);
        chk("a5_data", 32'(data), 32'hA5);
        chk("a5_fcnt", 32'(fcnt), 32'd0);
        chk("a5_latency", 32'(vcyc - s), 32'd678);

        // Bit period 2% short: 696 ns instead of 710 ns
        repeat (5) @(posedge clk);
        #1;
        send_frame(9'h000, 1'b0, 1'b1, 696);
        send_frame(9'h0FF, 1'b0, 1'b1, 696);
        send_frame(9'h03C, 1'b0, 1'b1, 696);
        repeat (80) @(posedge clk);
        #1;
        chk("b2b_vcnt", 32'(vcnt), 32'd4);
        chk("b2b_words", 32'(hist), 32'h0000FF3C);
        chk("b2b_fcnt", 32'(fcnt), 32'd0);

        // 20-cycle glitch: vote at tick 36 rejects it, busy drops HALF+SYNC+2 = 39 clocks after the edge
        @(posedge clk);
        #1;
        s = cyc;
        rx = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rx = 1'b1;
        wait_neg(s + 38);
        chk("glitch_busy_hi", 32'(busy), 32'd1);
        wait_neg(s + 39);
        chk("glitch_busy_lo", 32'(busy), 32'd0);
        repeat (150) @(posedge clk);
        #1;
        chk("glitch_vcnt", 32'(vcnt), 32'd4);
        chk("glitch_fcnt", 32'(fcnt), 32'd0);

        // 0x55 with a low stop bit: frame error, previous word kept
        @(posedge clk);
        #1;
        send_frame(9'h055, 1'b0, 1'b0, BIT_NS);
        repeat (150) @(posedge clk);
        #1;
        chk("ferr_fcnt", 32'(fcnt), 32'd1);
        chk("ferr_vcnt", 32'(vcnt), 32'd4);
        chk("ferr_data", 32'(data), 32'h3C);
        chk("ferr_busy", 32'(busy), 32'd0);

        // Line held low for 30 bit times
        @(posedge clk);
        #1;
        rx = 1'b0;
        #(29 * BIT_NS);
        @(negedge clk);
        chk("brk_busy_hi", 32'(busy), 32'd1);
        chk("brk_fcnt_once", 32'(fcnt), 32'd2);
        #(BIT_NS);
        rx = 1'b1;
        repeat (6) @(negedge clk);
        chk("brk_busy_lo", 32'(busy), 32'd0);
        repeat (150) @(posedge clk);
        #1;
        chk("brk_fcnt_after", 32'(fcnt), 32'd2);
        chk("brk_vcnt", 32'(vcnt), 32'd4);

        // Reset in the middle of data bit 1 of 0x81
        @(posedge clk);
        #1;
        rx = 1'b0;
        #(BIT_NS);
        rx = 1'b1;
        #(BIT_NS);
        rx = 1'b0;
        #305;
        chk("rst_mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_strobes_busy", 32'({valid, frame_err, parity_err, busy}), 32'h0);
        chk("rst_mid_data", 32'(data), 32'h0);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (150) @(posedge clk);
        #1;
        send_frame(9'h081, 1'b0, 1'b1, BIT_NS);
        repeat (20) @(posedge clk);
        #1;
        chk("post_rst_vcnt", 32'(vcnt), 32'd5);
        chk("post_rst_data", 32'(data), 32'h81);
        chk("post_rst_fcnt", 32'(fcnt), 32'd2);
        chk("perr_never", 32'(pcnt), 32'd0);
`endif

        chk("strobe_overlap", 32'(ovl), 32'd0);
        chk("outputs_known", 32'((^{valid, data, frame_err, parity_err, busy}) === 1'bx), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
